// File: rtl/ppl_hold_ctrl_if.sv
// Hold-controller bus: hazard/redirect/interrupt requests from the pipeline and
// the hold code, PC redirect, mepc write and interrupt accept returned to it.
interface ppl_hold_ctrl_if;
  logic [31:0] ID_inst_addr;
  logic        id_valid;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        mret;
  logic [31:0] mepc;
  logic        load_use;
  logic        mem_busy;
  logic        int_req;
  logic [31:0] int_vec;
  logic [1:0]  hold_flag;
  logic        pc_we;
  logic [31:0] pc_waddr;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        int_ack;

  // The hold controller itself.
  modport master (
    input  ID_inst_addr, id_valid, jump_flag, jump_addr, mret, mepc,
           load_use, mem_busy, int_req, int_vec,
    output hold_flag, pc_we, pc_waddr, mepc_we, mepc_wdata, int_ack
  );

  // The pipeline side that raises requests and obeys the hold code.
  modport slave (
    output ID_inst_addr, id_valid, jump_flag, jump_addr, mret, mepc,
           load_use, mem_busy, int_req, int_vec,
    input  hold_flag, pc_we, pc_waddr, mepc_we, mepc_wdata, int_ack
  );
endinterface

// File: rtl/ppl_hold_ctrl.sv
// Pipeline hold controller: jump/mret redirect, load-use stall and, when
// PPL_HOLD_INT_EN is defined, the drain/save/vector interrupt entry sequence.
module ppl_hold_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  ppl_hold_ctrl_if.master bus
);

  localparam logic [1:0] HOLD_NONE = 2'd0;
  localparam logic [1:0] HOLD_IF   = 2'd1;
  localparam logic [1:0] HOLD_EX   = 2'd2;
  localparam logic [1:0] HOLD_PPL  = 2'd3;

  logic        int_take;
  logic [1:0]  idle_hold;
  logic        idle_pc_we;
  logic [31:0] idle_pc_waddr;

  logic [1:0]  hold;
  logic        pc_we;
  logic [31:0] pc_waddr;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        int_ack;

  // NOTE: every variable gets a default before the priority chain, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    idle_hold     = HOLD_NONE;
    idle_pc_we    = 1'b0;
    idle_pc_waddr = '0;
    if (bus.jump_flag) begin
      idle_hold     = HOLD_EX;
      idle_pc_we    = 1'b1;
      idle_pc_waddr = bus.jump_addr;
    end else if (bus.mret) begin
      idle_hold     = HOLD_EX;
      idle_pc_we    = 1'b1;
      idle_pc_waddr = bus.mepc;
    end else if (int_take) begin
      idle_hold     = HOLD_PPL;
    end else if (bus.load_use) begin
      idle_hold     = HOLD_IF;
    end
  end

`ifdef PPL_HOLD_INT_EN
  typedef enum logic [1:0] {IDLE, DRAIN, SAVE, VEC} state_t;

  state_t      state;
  logic [31:0] saved_pc;

  // A redirect in the same cycle defers the interrupt so the flushed path is
  // never recorded as the interrupted instruction.
  assign int_take = bus.int_req & bus.id_valid & ~bus.jump_flag & ~bus.mret;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; saved_pc is a single register and is reset with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      saved_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (int_take) begin
            state    <= DRAIN;
            saved_pc <= bus.ID_inst_addr;
          end
        end
        DRAIN:   if (!bus.mem_busy) state <= SAVE;
        SAVE:    state <= VEC;
        VEC:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hold       = HOLD_NONE;
    pc_we      = 1'b0;
    pc_waddr   = '0;
    mepc_we    = 1'b0;
    mepc_wdata = '0;
    int_ack    = 1'b0;
    case (state)
      IDLE: begin
        hold     = idle_hold;
        pc_we    = idle_pc_we;
        pc_waddr = idle_pc_waddr;
      end
      DRAIN: hold = HOLD_PPL;
      SAVE: begin
        hold       = HOLD_PPL;
        mepc_we    = 1'b1;
        mepc_wdata = saved_pc;
      end
      VEC: begin
        hold     = HOLD_PPL;
        pc_we    = 1'b1;
        pc_waddr = bus.int_vec;
        int_ack  = 1'b1;
      end
      default: hold = HOLD_NONE;
    endcase
  end
`else
  // Interrupt support compiled out: the controller is purely combinational.
  logic unused_int_inputs;
  assign unused_int_inputs = ^{clk, rst_n, bus.int_req, bus.int_vec,
                               bus.mem_busy, bus.id_valid, bus.ID_inst_addr};
  assign int_take = 1'b0;

  always_comb begin
    hold       = idle_hold;
    pc_we      = idle_pc_we;
    pc_waddr   = idle_pc_waddr;
    mepc_we    = 1'b0;
    mepc_wdata = '0;
    int_ack    = 1'b0;
  end
`endif

  assign bus.hold_flag  = hold;
  assign bus.pc_we      = pc_we;
  assign bus.pc_waddr   = pc_waddr;
  assign bus.mepc_we    = mepc_we;
  assign bus.mepc_wdata = mepc_wdata;
  assign bus.int_ack    = int_ack;

endmodule

// File: tb/tb_ppl_hold_ctrl.sv
// Self-checking bench for ppl_hold_ctrl; expectations follow PPL_HOLD_INT_EN so
// the same bench covers both builds.
module tb_ppl_hold_ctrl;

`ifdef PPL_HOLD_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        idv;
    logic        jf;
    logic [31:0] ja;
    logic        mr;
    logic [31:0] mepc;
    logic        lu;
    logic        mb;
    logic        ir;
    logic [31:0] iv;
  } in_t;

  typedef struct packed {
    logic [1:0]  hold;
    logic        pc_we;
    logic [31:0] pc_waddr;
    logic        mepc_we;
    logic [31:0] mepc_wdata;
    logic        int_ack;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];

  ppl_hold_ctrl_if bus ();

  ppl_hold_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic [31:0] addr, logic idv, logic jf, logic [31:0] ja,
                                logic mr, logic [31:0] mepc, logic lu, logic mb,
                                logic ir, logic [31:0] iv);
    return '{addr, idv, jf, ja, mr, mepc, lu, mb, ir, iv};
  endfunction

  function automatic out_t o(logic [1:0] h, logic we, logic [31:0] wa,
                             logic mwe, logic [31:0] mwd, logic ack);
    return '{h, we, wa, mwe, mwd, ack};
  endfunction

  task automatic drive(input in_t s);
    bus.ID_inst_addr = s.addr;
    bus.id_valid     = s.idv;
    bus.jump_flag    = s.jf;
    bus.jump_addr    = s.ja;
    bus.mret         = s.mr;
    bus.mepc         = s.mepc;
    bus.load_use     = s.lu;
    bus.mem_busy     = s.mb;
    bus.int_req      = s.ir;
    bus.int_vec      = s.iv;
  endtask

  function automatic out_t sample();
    return '{bus.hold_flag, bus.pc_we, bus.pc_waddr, bus.mepc_we, bus.mepc_wdata, bus.int_ack};
  endfunction

  task automatic test_reset();
    out_t got, e;
    drive('0);
    rst_n = 1'b0;
    #3;
    exp_q.push_back(o(0, 0, 0, 0, 0, 0));
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL reset_in got %h exp %h", got, e);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(o(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL reset_out got %h exp %h", got, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jump();
    in_t  stim [6];
    out_t expv [6];
    out_t got, e;
    stim = '{mk_in(0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 0),
             mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             mk_in(0, 0, 0, 0, 1, 32'h1234, 0, 0, 0, 0),
             mk_in(0, 0, 1, 32'h80, 1, 32'h1234, 0, 0, 0, 0),
             mk_in(0, 0, 1, 32'hC0, 0, 0, 1, 0, 0, 0),
             mk_in(0, 0, 0, 0, 1, 32'h5678, 1, 0, 0, 0)};
    expv = '{o(2, 1, 32'h40, 0, 0, 0), o(0, 0, 0, 0, 0, 0),
             o(2, 1, 32'h1234, 0, 0, 0), o(2, 1, 32'h80, 0, 0, 0),
             o(2, 1, 32'hC0, 0, 0, 0), o(2, 1, 32'h5678, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]); exp_q.push_back(expv[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL jump[%0d] got %h exp %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t  stim [3];
    out_t expv [3];
    out_t got, e;
    stim = '{mk_in(0, 1, 0, 0, 0, 0, 1, 0, 0, 0),
             mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
             mk_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
    expv = '{o(1, 0, 0, 0, 0, 0), o(0, 0, 0, 0, 0, 0), o(1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      drive(stim[i]); exp_q.push_back(expv[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL load_use[%0d] got %h exp %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Accept, DRAIN, SAVE, VEC with stray jump/mret/load_use that must be ignored.
  task automatic test_int_basic();
    in_t  stim [6];
    out_t expv [6];
    out_t got, e;
    stim = '{mk_in(32'h100, 1, 0, 0, 0, 0, 1, 0, 1, 32'h800),
             mk_in(32'h104, 1, 0, 0, 0, 0, 1, 0, 1, 32'h800),
             mk_in(32'h104, 1, 1, 32'h44, 0, 0, 0, 0, 1, 32'h800),
             mk_in(32'h104, 1, 0, 0, 1, 32'h66, 0, 0, 1, 32'h800),
             mk_in(32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 32'h800),
             mk_in(32'h108, 0, 0, 0, 0, 0, 0, 0, 1, 32'h800)};
    expv = '{INT_EN ? o(3, 0, 0, 0, 0, 0) : o(1, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 0, 0, 0) : o(1, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 1, 32'h100, 0) : o(2, 1, 32'h44, 0, 0, 0),
             INT_EN ? o(3, 1, 32'h800, 0, 0, 1) : o(2, 1, 32'h66, 0, 0, 0),
             o(0, 0, 0, 0, 0, 0),
             o(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]); exp_q.push_back(expv[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL int_basic[%0d] got %h exp %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_delay();
    in_t  stim [7];
    out_t expv [7];
    out_t got, e;
    stim = '{mk_in(32'h300, 1, 0, 0, 0, 0, 0, 1, 1, 32'hC00),
             mk_in(32'h304, 1, 0, 0, 0, 0, 0, 1, 1, 32'hC00),
             mk_in(32'h304, 1, 0, 0, 0, 0, 0, 1, 1, 32'hC00),
             mk_in(32'h304, 1, 0, 0, 0, 0, 0, 0, 1, 32'hC00),
             mk_in(32'h304, 1, 0, 0, 0, 0, 0, 0, 1, 32'hC00),
             mk_in(32'h304, 1, 0, 0, 0, 0, 0, 0, 1, 32'hC00),
             mk_in(32'h304, 1, 0, 0, 0, 0, 0, 0, 0, 32'hC00)};
    expv = '{INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 1, 32'h300, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 1, 32'hC00, 0, 0, 1) : o(0, 0, 0, 0, 0, 0),
             o(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      drive(stim[i]); exp_q.push_back(expv[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL mem_delay[%0d] got %h exp %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Interrupt deferred by a jump, then by an mret, back to back.
  task automatic test_back_to_back();
    in_t  stim [8];
    out_t expv [8];
    out_t got, e;
    stim = '{mk_in(32'h1F0, 1, 1, 32'h200, 0, 0, 0, 0, 1, 32'h900),
             mk_in(32'h0,   0, 0, 0, 0, 0, 0, 0, 1, 32'h900),
             mk_in(32'h200, 1, 0, 0, 0, 0, 0, 0, 1, 32'h900),
             mk_in(32'h204, 1, 0, 0, 0, 0, 0, 0, 1, 32'h900),
             mk_in(32'h204, 1, 0, 0, 0, 0, 0, 0, 1, 32'h900),
             mk_in(32'h204, 1, 0, 0, 0, 0, 0, 0, 1, 32'h900),
             mk_in(32'h204, 1, 0, 0, 1, 32'h500, 0, 0, 1, 32'h900),
             mk_in(32'h500, 1, 0, 0, 0, 0, 0, 0, 0, 32'h900)};
    expv = '{o(2, 1, 32'h200, 0, 0, 0),
             o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 0, 0, 1, 32'h200, 0) : o(0, 0, 0, 0, 0, 0),
             INT_EN ? o(3, 1, 32'h900, 0, 0, 1) : o(0, 0, 0, 0, 0, 0),
             o(2, 1, 32'h500, 0, 0, 0),
             o(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]); exp_q.push_back(expv[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL back_to_back[%0d] got %h exp %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    out_t got, e;
    drive(mk_in(32'h700, 1, 0, 0, 0, 0, 0, 0, 1, 32'hA00));
    exp_q.push_back(INT_EN ? o(3, 0, 0, 0, 0, 0) : o(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL rst_mid_accept got %h exp %h", got, e);
    end
    @(posedge clk); #1;
    drive(mk_in(32'h704, 1, 0, 0, 0, 0, 0, 0, 1, 32'hA00));
    @(posedge clk); #1;
    drive('0);
    exp_q.push_back(INT_EN ? o(3, 0, 0, 1, 32'h700, 0) : o(0, 0, 0, 0, 0, 0));
    #1;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL rst_mid_save got %h exp %h", got, e);
    end
    rst_n = 1'b0;
    exp_q.push_back(o(0, 0, 0, 0, 0, 0));
    #1;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL rst_mid_async got %h exp %h", got, e);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(o(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL rst_mid_after[%0d] got %h exp %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_load_use();
    test_int_basic();
    test_mem_delay();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
